// File: rtl/lsp_decode_buf_pkg.sv
// Shared constants for the decoder LSP rebuild: ROM/scratch bases, LSP order and expansion gaps.
package lsp_decode_buf_pkg;

   localparam int unsigned M  = 10;
   localparam int unsigned NC = 5;

   localparam logic [15:0] GAP1 = 16'd10;
   localparam logic [15:0] GAP2 = 16'd5;

   // LSPCB1 spans {code0, j} (11 bits); LSPCB2 spans {code, j} (9 bits).
   localparam logic [11:0] LSPCB1         = 12'h000;
   localparam logic [11:0] LSPCB2         = 12'h800;
   localparam logic [11:0] LSP_DECODE_BUF = 12'h040;

endpackage

// File: rtl/lsp_decode_buf_if.sv
// Request, memory and shared-ALU signals of lsp_decode_buf; slave is the decoder side.
interface lsp_decode_buf_if;

   logic        start;
   logic [6:0]  code0;
   logic [4:0]  code1;
   logic [4:0]  code2;
   logic [31:0] memIn;
   logic [11:0] memWriteAddr;
   logic        memWriteEn;
   logic [31:0] memOut;
   logic [11:0] constMemAddr;
   logic [31:0] constMemIn;
   logic [15:0] addOutA;
   logic [15:0] addOutB;
   logic [15:0] addIn;
   logic [15:0] subOutA;
   logic [15:0] subOutB;
   logic [15:0] subIn;
   logic        done;

   modport master (
      output start, code0, code1, code2, memIn, constMemIn, addIn, subIn,
      input  memWriteAddr, memWriteEn, memOut, constMemAddr,
      input  addOutA, addOutB, subOutA, subOutB, done
   );

   modport slave (
      input  start, code0, code1, code2, memIn, constMemIn, addIn, subIn,
      output memWriteAddr, memWriteEn, memOut, constMemAddr,
      output addOutA, addOutB, subOutA, subOutB, done
   );

endinterface

// File: rtl/lsp_decode_buf.sv
// Rebuilds buf[j] = lspcb1[code0][j] + lspcb2[code1/2][j], then runs two spacing passes (GAP1, GAP2).
module lsp_decode_buf
   import lsp_decode_buf_pkg::*;
(
   input logic              clk,
   input logic              reset,
   lsp_decode_buf_if.slave  bus
);

   typedef enum logic [3:0] {
      StInit,
      StCbRd1,
      StCbRd2,
      StCbAdd,
      StExpRd1,
      StExpRd2,
      StExpCalc,
      StExpTmp,
      StExpUpd1,
      StExpUpd2,
      StExpNext
   } state_e;

   localparam logic [3:0] LastJ = 4'(M - 1);

   state_e      state_q, state_d;
   logic [3:0]  j_q, j_d;
   logic        pass_q, pass_d;
   logic [6:0]  code0_q, code0_d;
   logic [4:0]  code1_q, code1_d;
   logic [4:0]  code2_q, code2_d;
   logic [15:0] cb1_q, cb1_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] diff_q, diff_d;
   logic [15:0] tmp_q, tmp_d;

   logic [4:0]  sel;
   logic [11:0] buf_j;
   logic [11:0] buf_jm1;
   logic        tmp_pos;
   logic        unused_hi;

   assign sel       = (32'(j_q) < NC) ? code1_q : code2_q;
   assign buf_j     = LSP_DECODE_BUF + {8'd0, j_q};
   assign buf_jm1   = LSP_DECODE_BUF + {8'd0, j_q - 4'd1};
   assign tmp_pos   = !tmp_q[15] && (tmp_q != 16'd0);
   assign unused_hi = ^{bus.memIn[31:16], bus.constMemIn[31:16]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StInit;
         j_q     <= '0;
         pass_q  <= 1'b0;
         code0_q <= '0;
         code1_q <= '0;
         code2_q <= '0;
         cb1_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         tmp_q   <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         pass_q  <= pass_d;
         code0_q <= code0_d;
         code1_q <= code1_d;
         code2_q <= code2_d;
         cb1_q   <= cb1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         tmp_q   <= tmp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      pass_d  = pass_q;
      code0_d = code0_q;
      code1_d = code1_q;
      code2_d = code2_q;
      cb1_d   = cb1_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      tmp_d   = tmp_q;

      bus.memWriteAddr = '0;
      bus.memWriteEn   = 1'b0;
      bus.memOut       = '0;
      bus.constMemAddr = '0;
      bus.addOutA      = '0;
      bus.addOutB      = '0;
      bus.subOutA      = '0;
      bus.subOutB      = '0;
      bus.done         = 1'b0;

      unique case (state_q)
         StInit: begin
            if (bus.start) begin
               code0_d = bus.code0;
               code1_d = bus.code1;
               code2_d = bus.code2;
               j_d     = '0;
               state_d = StCbRd1;
            end
         end
         StCbRd1: begin
            bus.constMemAddr = LSPCB1 + {1'b0, code0_q, j_q};
            state_d          = StCbRd2;
         end
         StCbRd2: begin
            cb1_d            = bus.constMemIn[15:0];
            bus.constMemAddr = LSPCB2 + {3'b000, sel, j_q};
            state_d          = StCbAdd;
         end
         StCbAdd: begin
            bus.addOutA      = cb1_q;
            bus.addOutB      = bus.constMemIn[15:0];
            bus.memWriteAddr = buf_j;
            bus.memWriteEn   = 1'b1;
            bus.memOut       = {16'd0, bus.addIn};
            j_d              = j_q + 4'd1;
            state_d          = StCbRd1;
            if (j_q == LastJ) begin
               pass_d  = 1'b0;
               j_d     = 4'd1;
               state_d = StExpRd1;
            end
         end
         StExpRd1: begin
            bus.memWriteAddr = buf_jm1;
            state_d          = StExpRd2;
         end
         StExpRd2: begin
            a_d              = bus.memIn[15:0];
            bus.memWriteAddr = buf_j;
            state_d          = StExpCalc;
         end
         StExpCalc: begin
            b_d         = bus.memIn[15:0];
            bus.subOutA = a_q;
            bus.subOutB = bus.memIn[15:0];
            diff_d      = bus.subIn;
            state_d     = StExpTmp;
         end
         StExpTmp: begin
            bus.addOutA = diff_q;
            bus.addOutB = pass_q ? GAP2 : GAP1;
            tmp_d       = {bus.addIn[15], bus.addIn[15:1]};
            state_d     = StExpUpd1;
         end
         StExpUpd1: begin
            state_d = StExpNext;
            if (tmp_pos) begin
               bus.subOutA      = a_q;
               bus.subOutB      = tmp_q;
               bus.memWriteAddr = buf_jm1;
               bus.memWriteEn   = 1'b1;
               bus.memOut       = {16'd0, bus.subIn};
               state_d          = StExpUpd2;
            end
         end
         StExpUpd2: begin
            bus.addOutA      = b_q;
            bus.addOutB      = tmp_q;
            bus.memWriteAddr = buf_j;
            bus.memWriteEn   = 1'b1;
            bus.memOut       = {16'd0, bus.addIn};
            state_d          = StExpNext;
         end
         StExpNext: begin
            if (j_q < LastJ) begin
               j_d     = j_q + 4'd1;
               state_d = StExpRd1;
            end else if (!pass_q) begin
               pass_d  = 1'b1;
               j_d     = 4'd1;
               state_d = StExpRd1;
            end else begin
               bus.done = 1'b1;
               state_d  = StInit;
            end
         end
         default: state_d = StInit;
      endcase
   end

endmodule
